// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder with a fixed request-to-response latency.
// Byte-lane writes commit at the end of the response cycle; reads return data in the response cycle.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_valid_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ready_q, valid_q;
    logic [31:0]     rdata_q;

    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      sel_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept;
    logic            resp_d;
    logic            is_read_d;
    logic [AW-1:0]   idx_in;
    logic [AW-1:0]   rd_idx;
    logic            unused_addr_bits;

    assign idx_in           = mem_addr_i[AW+1:2];
    assign unused_addr_bits = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};
    assign accept           = (state_q == IDLE) && mem_req_i;
    // With LATENCY=1 the read launches on the accept edge, before the index register is loaded.
    assign rd_idx           = (state_q == IDLE) ? idx_in : idx_q;
    assign is_read_d        = (state_q == IDLE) ? !mem_we_i : !we_q;
    assign resp_d           = (state_d == RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= resp_d;
            valid_q <= resp_d && is_read_d;
            rdata_q <= (resp_d && is_read_d) ? mem_q[rd_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= mem_we_i;
            idx_q   <= idx_in;
            wdata_q <= mem_wdata_i;
            sel_q   <= mem_sel_i;
        end
    end

    // Storage is never reset; a reset during RESP suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == RESP) && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_valid_o = valid_q;
    assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2/3/1) driven one at a time,
// with expected responses queued at request time and matched when mem_ready_o pulses.
module tb_data_mem_responder;
    typedef struct {
        int          dut;
        int          cyc;
        logic        vld;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, req_c;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        vld_a, vld_b, vld_c;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(16384), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .mem_req_i(req_a), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel), .mem_rdata_o(rd_a),
        .mem_ready_o(rdy_a), .mem_valid_o(vld_a)
    );
    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .mem_req_i(req_b), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel), .mem_rdata_o(rd_b),
        .mem_ready_o(rdy_b), .mem_valid_o(vld_b)
    );
    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_c (
        .clk(clk), .rst(rst), .mem_req_i(req_c), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel), .mem_rdata_o(rd_c),
        .mem_ready_o(rdy_c), .mem_valid_o(vld_c)
    );

    function automatic int lat_of(input int id);
        return (id == 0) ? 2 : (id == 1) ? 3 : 1;
    endfunction

    function automatic logic rdy_of(input int id);
        return (id == 0) ? rdy_a : (id == 1) ? rdy_b : rdy_c;
    endfunction

    function automatic logic vld_of(input int id);
        return (id == 0) ? vld_a : (id == 1) ? vld_b : vld_c;
    endfunction

    function automatic logic [31:0] rd_of(input int id);
        return (id == 0) ? rd_a : (id == 1) ? rd_b : rd_c;
    endfunction

    task automatic set_req(input int id, input logic v);
        if (id == 0) req_a = v;
        else if (id == 1) req_b = v;
        else req_c = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input int at, input logic is_rd, input logic [31:0] d);
        exp_t e;
        e.dut  = id;
        e.cyc  = at;
        e.vld  = is_rd;
        e.data = is_rd ? d : 32'h0;
        sb.push_back(e);
    endtask

    task automatic mon(input int id, input logic rdy, input logic vld, input logic [31:0] rd);
        exp_t e;
        if (rdy) begin
            chk($sformatf("d%0d_resp_expected", id), 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("d%0d_resp_dut", id), 32'(id), 32'(e.dut));
                chk($sformatf("d%0d_resp_cycle", id), 32'(cyc), 32'(e.cyc));
                chk($sformatf("d%0d_resp_valid", id), 32'(vld), 32'(e.vld));
                chk($sformatf("d%0d_resp_rdata", id), rd, e.data);
            end
        end else begin
            chk($sformatf("d%0d_idle_valid", id), 32'(vld), 32'd0);
            chk($sformatf("d%0d_idle_rdata", id), rd, 32'h0);
        end
    endtask

    always @(negedge clk) if (mon_en) mon(0, rdy_a, vld_a, rd_a);
    always @(negedge clk) if (mon_en) mon(1, rdy_b, vld_b, rd_b);
    always @(negedge clk) if (mon_en) mon(2, rdy_c, vld_c, rd_c);

    task automatic wait_resp(input int id);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = rdy_of(id);
        end
        chk($sformatf("d%0d_resp_seen", id), 32'(got), 32'd1);
        @(posedge clk);
        #1;
        set_req(id, 1'b0);
    endtask

    task automatic txn(input int id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] sel, input logic [31:0] exp_rd);
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_sel   = sel;
        set_req(id, 1'b1);
        push_exp(id, cyc + lat_of(id), !we, exp_rd);
        wait_resp(id);
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input int id, input string tag);
        chk($sformatf("d%0d_%s_ready", id, tag), 32'(rdy_of(id)), 32'd0);
        chk($sformatf("d%0d_%s_valid", id, tag), 32'(vld_of(id)), 32'd0);
        chk($sformatf("d%0d_%s_rdata", id, tag), rd_of(id), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) chk_zero(id, "reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Full-word write at T=10 then read at T=14
        goto_cyc(10);
        txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0);
        goto_cyc(14);
        txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF);

        // Byte-lane writes and the sel=0 no-op
        txn(0, 1'b1, 32'h40, 32'h11223344, 4'hF, 32'h0);
        txn(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 32'h0);
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11BB33DD);
        txn(0, 1'b1, 32'h40, 32'h99999999, 4'b0000, 32'h0);
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11BB33DD);

        // Reset during BUSY abandons the write; req held through reset is ignored
        txn(0, 1'b1, 32'h80, 32'h0, 4'hF, 32'h0);
        mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'hFFFFFFFF; mem_sel = 4'hF;
        req_a = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_we = 1'b0;
        @(posedge clk); #1;
        chk_zero(0, "rst_busy");
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(0, cyc + 2, 1'b1, 32'h0);
        wait_resp(0);

        // Reset during RESP suppresses the pending write
        txn(0, 1'b1, 32'h84, 32'h0, 4'hF, 32'h0);
        mem_we = 1'b1; mem_addr = 32'h84; mem_wdata = 32'hFFFFFFFF; mem_sel = 4'hF;
        req_a = 1'b1;
        push_exp(0, cyc + 2, 1'b0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        req_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero(0, "rst_resp");
        txn(0, 1'b0, 32'h84, 32'h0, 4'h0, 32'h0);

        // Wrap and ignored addr[1:0] with 16 words
        txn(1, 1'b1, 32'h43, 32'h5A5A5A5A, 4'hF, 32'h0);
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h5A5A5A5A);
        txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A);

        // Request dropped one cycle after acceptance still completes
        mem_we = 1'b0; mem_addr = 32'h40;
        req_b = 1'b1;
        push_exp(1, cyc + 3, 1'b1, 32'h5A5A5A5A);
        @(posedge clk); #1;
        req_b = 1'b0;
        wait_resp(1);

        // Request held continuously: responses at T+3 and T+7
        t = cyc;
        mem_we = 1'b0; mem_addr = 32'h40;
        req_b = 1'b1;
        push_exp(1, t + 3, 1'b1, 32'h5A5A5A5A);
        push_exp(1, t + 7, 1'b1, 32'h5A5A5A5A);
        repeat (7) @(posedge clk);
        #1;
        req_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // LATENCY=1 back-to-back alternating write/read with req held
        req_c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_we    = (i % 2 == 0);
            mem_addr  = 32'h20 + 32'((i / 2) * 4);
            mem_wdata = 32'hC0DE0000 + 32'(i);
            mem_sel   = 4'hF;
            push_exp(2, cyc + 1, !mem_we, 32'hC0DE0000 + 32'(i - 1));
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        req_c = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
